// File: rtl/adma_dm_src_axis.sv
// adma_dm_src_axis: AXI-Stream source ingress for the DMA data mover.
// Forwards tlen+1 beats per descriptor, zero-padding short packets and draining long ones.
module adma_dm_src_axis #(
    parameter  int DMA_CHN_NUM    = 4,
    parameter  int ATX_LEN_W      = 8,
    parameter  int ATX_SRC_DATA_W = 256,
    parameter  int ATX_NUM_OSTD   = DMA_CHN_NUM,
    localparam int DMA_CHN_NUM_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [DMA_CHN_NUM_W-1:0]  atx_chn_id,
    input  logic [ATX_LEN_W-1:0]      atx_tlen,
    input  logic                      atx_vld,
    output logic                      atx_rdy,
    output logic [ATX_SRC_DATA_W-1:0] atx_rdata,
    output logic                      atx_rdata_vld,
    input  logic                      atx_rdata_rdy,
    output logic                      atx_done    [0:DMA_CHN_NUM-1],
    output logic                      atx_src_err [0:DMA_CHN_NUM-1],
    input  logic [ATX_SRC_DATA_W-1:0] s_tdata_i,
    input  logic                      s_tlast_i,
    input  logic                      s_tvalid_i,
    output logic                      s_tready_o
);
    localparam int AW = $clog2(ATX_NUM_OSTD);
    localparam int FW = DMA_CHN_NUM_W + ATX_LEN_W;

    typedef enum logic [1:0] {IDLE, XFER, PAD, DRAIN} state_e;

    state_e                    state_q, state_d;
    logic [ATX_LEN_W-1:0]      cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [AW:0]               wr_q, rd_q, used;
    logic [FW-1:0]             mem_q [ATX_NUM_OSTD];
    logic [ATX_SRC_DATA_W-1:0] data_q, load_data;
    logic                      vld_q;
    logic                      done_q [0:DMA_CHN_NUM-1];
    logic                      serr_q [0:DMA_CHN_NUM-1];
    logic                      empty, full, push, load_ok, last_beat, load, fin, fin_err;
    logic [DMA_CHN_NUM_W-1:0]  head_chn;
    logic [ATX_LEN_W-1:0]      head_len;

    assign used      = wr_q - rd_q;
    assign empty     = (wr_q == rd_q);
    assign full      = (used == (AW+1)'(ATX_NUM_OSTD));
    assign atx_rdy   = ~full;
    assign push      = atx_vld & atx_rdy;
    assign {head_chn, head_len} = mem_q[rd_q[AW-1:0]];
    assign load_ok   = ~vld_q | atx_rdata_rdy;
    assign last_beat = (cnt_q == head_len);

    assign atx_rdata     = data_q;
    assign atx_rdata_vld = vld_q;
    assign atx_done      = done_q;
    assign atx_src_err   = serr_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        s_tready_o = 1'b0;
        load       = 1'b0;
        load_data  = '0;
        fin        = 1'b0;
        fin_err    = err_q;
        case (state_q)
            IDLE: state_d = empty ? IDLE : XFER;
            XFER: begin
                s_tready_o = load_ok;
                if (s_tvalid_i && load_ok) begin
                    load      = 1'b1;
                    load_data = s_tdata_i;
                    if (last_beat) begin
                        fin     = 1'b1;
                        fin_err = err_q | ~s_tlast_i;
                        state_d = !s_tlast_i ? DRAIN : (used > (AW+1)'(1)) ? XFER : IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (s_tlast_i) begin
                            err_d   = 1'b1;
                            state_d = PAD;
                        end
                    end
                end
            end
            PAD: if (load_ok) begin
                load = 1'b1;
                if (last_beat) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                s_tready_o = 1'b1;
                state_d    = (s_tvalid_i && s_tlast_i) ? IDLE : DRAIN;
            end
        endcase
        if (fin) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            for (int i = 0; i < DMA_CHN_NUM; i++) begin
                done_q[i] <= 1'b0;
                serr_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (fin) rd_q <= rd_q + 1'b1;
            if (load) begin
                data_q <= load_data;
                vld_q  <= 1'b1;
            end else if (atx_rdata_rdy) begin
                vld_q  <= 1'b0;
            end
            // Completion is reported against the head entry before it is popped.
            for (int i = 0; i < DMA_CHN_NUM; i++) begin
                done_q[i] <= fin && (head_chn == DMA_CHN_NUM_W'(i));
                serr_q[i] <= fin && fin_err && (head_chn == DMA_CHN_NUM_W'(i));
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {atx_chn_id, atx_tlen};
    end
endmodule

// File: tb/tb_adma_dm_src_axis.sv
// tb_adma_dm_src_axis: randomized bench for adma_dm_src_axis against a packet-level model.
module tb_adma_dm_src_axis;
    localparam int NCH = 4, LW = 8, DW = 256, OSTD = 4;

    logic          aclk = 1'b0, aresetn = 1'b0;
    logic [1:0]    atx_chn_id;
    logic [LW-1:0] atx_tlen;
    logic          atx_vld, atx_rdy;
    logic [DW-1:0] atx_rdata;
    logic          atx_rdata_vld, atx_rdata_rdy;
    logic          atx_done    [0:NCH-1];
    logic          atx_src_err [0:NCH-1];
    logic [DW-1:0] s_tdata_i;
    logic          s_tlast_i, s_tvalid_i, s_tready_o;
    int            checks = 0, errors = 0, tid = 0, cyc = 0;

    always #5 aclk = ~aclk;

    adma_dm_src_axis #(.DMA_CHN_NUM(NCH), .ATX_LEN_W(LW), .ATX_SRC_DATA_W(DW), .ATX_NUM_OSTD(OSTD)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .atx_chn_id(atx_chn_id), .atx_tlen(atx_tlen), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
        .atx_rdata(atx_rdata), .atx_rdata_vld(atx_rdata_vld), .atx_rdata_rdy(atx_rdata_rdy),
        .atx_done(atx_done), .atx_src_err(atx_src_err),
        .s_tdata_i(s_tdata_i), .s_tlast_i(s_tlast_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o)
    );

    typedef struct { logic [DW-1:0] d; logic l; } sbeat_t;
    typedef struct { logic [DW-1:0] d; int id; logic l; } obeat_t;
    typedef struct { logic [1:0] c; logic [LW-1:0] t; } desc_t;
    typedef struct { int c; logic e; int id; } done_t;

    sbeat_t sq[$];
    obeat_t oq[$];
    desc_t  dq[$];
    done_t  xq[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DW/32; i++) r = {r[DW-33:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [NCH-1:0] dvec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = atx_done[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] evec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = atx_src_err[i];
        return v;
    endfunction

    // A transaction of n=tlen+1 beats forwards min(L,n) packet beats then zeros; error iff L != n.
    task automatic add(input int c, input int t, input int len);
        logic [DW-1:0] d;
        int n = t + 1;
        for (int i = 0; i < len; i++) begin
            d = rnd();
            sq.push_back('{d, i == len-1});
            if (i < n) oq.push_back('{d, tid, i == n-1});
        end
        for (int i = len; i < n; i++) oq.push_back('{'0, tid, i == n-1});
        dq.push_back('{c[1:0], t[LW-1:0]});
        xq.push_back('{c, len != n, tid});
        tid++;
    endtask

    task automatic run(input int p_rdy, input int p_v, input bit gate, output int first, output int last);
        logic          held = 1'b0;
        logic [DW-1:0] hd = '0;
        int            budget = 20000;
        done_t         x;
        obeat_t        o;
        first = -1;
        last  = -1;
        while ((dq.size() || sq.size() || oq.size() || xq.size()) && budget > 0) begin
            @(posedge aclk); #1;
            cyc++;
            budget--;
            atx_vld = dq.size() > 0 && (atx_vld || $urandom_range(99) < p_v);
            if (dq.size()) begin
                atx_chn_id = dq[0].c;
                atx_tlen   = dq[0].t;
            end
            s_tvalid_i = sq.size() > 0 && !(gate && dq.size() > 0) && (s_tvalid_i || $urandom_range(99) < p_v);
            if (sq.size()) begin
                s_tdata_i = sq[0].d;
                s_tlast_i = sq[0].l;
            end
            atx_rdata_rdy = $urandom_range(99) < p_rdy;
            @(negedge aclk);
            if (dvec() != 0 || evec() != 0) begin
                chk("done_avail", xq.size() > 0, 1);
                if (xq.size() > 0) begin
                    x = xq.pop_front();
                    chk("done_vec", dvec(), 4'b1 << x.c);
                    chk("err_vec", evec(), x.e ? 4'b1 << x.c : 4'b0);
                    chk("done_time", oq.size() > 0 && oq[0].id == x.id && oq[0].l && atx_rdata_vld, 1);
                end
            end
            if (held) begin
                chk("hold_vld", atx_rdata_vld, 1);
                chk("hold_data", atx_rdata, hd);
            end
            held = atx_rdata_vld && !atx_rdata_rdy;
            hd   = atx_rdata;
            if (atx_rdata_vld && atx_rdata_rdy) begin
                chk("beat_avail", oq.size() > 0, 1);
                if (oq.size() > 0) begin
                    o = oq.pop_front();
                    chk("beat", atx_rdata, o.d);
                end
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (s_tvalid_i && s_tready_o) void'(sq.pop_front());
            if (atx_vld && atx_rdy) void'(dq.pop_front());
        end
        chk("timeout", budget > 0, 1);
        @(posedge aclk); #1;
        atx_vld    = 1'b0;
        s_tvalid_i = 1'b0;
    endtask

    initial begin
        int f, l, t, n, len;
        atx_vld = 1'b0; atx_chn_id = '0; atx_tlen = '0; atx_rdata_rdy = 1'b1;
        s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_tdata_i = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_vld", atx_rdata_vld, 0);
        chk("rst_data", atx_rdata, 0);
        chk("rst_done", dvec(), 0);
        chk("rst_err", evec(), 0);
        chk("rst_tready", s_tready_o, 0);
        chk("rst_rdy", atx_rdy, 1);
        @(negedge aclk) aresetn = 1'b1;

        add(2, 3, 4);
        run(100, 100, 1, f, l);
        chk("normal_gap", l - f, 3);
        add(0, 1, 2);
        add(1, 0, 1);
        run(100, 100, 1, f, l);
        chk("b2b_gap", l - f, 2);
        add(1, 4, 2);
        add(2, 1, 2);
        run(100, 100, 0, f, l);
        add(3, 1, 5);
        add(0, 2, 3);
        run(100, 100, 0, f, l);
        add(2, 15, 16);
        run(50, 100, 0, f, l);
        add(1, 0, 3);
        add(3, 255, 256);
        add(0, 255, 100);
        add(2, 0, 1);
        run(70, 80, 0, f, l);
        for (int i = 0; i < 40; i++) begin
            t = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 12);
            n = t + 1;
            case ($urandom_range(4))
                0:       len = (n > 1) ? $urandom_range(1, n-1) : n;
                1:       len = n + $urandom_range(1, 4);
                default: len = n;
            endcase
            add($urandom_range(NCH-1), t, len);
        end
        run(60, 70, 0, f, l);

        for (int i = 0; i < OSTD; i++) begin
            atx_vld = 1'b1; atx_chn_id = 2'(i); atx_tlen = 8'd7;
            @(negedge aclk);
            chk("fill_rdy", atx_rdy, 1);
            @(posedge aclk); #1;
        end
        atx_vld = 1'b0;
        @(negedge aclk);
        chk("full_rdy", atx_rdy, 0);
        @(posedge aclk); #1;
        s_tvalid_i = 1'b1; s_tlast_i = 1'b0; s_tdata_i = rnd();
        repeat (2) @(posedge aclk);
        #1 s_tvalid_i = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_vld", atx_rdata_vld, 0);
        chk("mid_rst_data", atx_rdata, 0);
        chk("mid_rst_tready", s_tready_o, 0);
        chk("mid_rst_rdy", atx_rdy, 1);
        repeat (3) begin
            @(negedge aclk);
            chk("mid_rst_done", dvec(), 0);
        end
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            chk("post_rst_done", dvec(), 0);
        end
        chk("post_rst_rdy", atx_rdy, 1);
        chk("post_rst_tready", s_tready_o, 0);
        add(1, 3, 4);
        run(80, 80, 0, f, l);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
